// File: rtl/doll_gesture_sequencer.sv
// Pose sequencer for the doll's two arm servos: plays one timed gesture per accepted
// request and an optional idle wave loop, with every step timed by a tick prescaler.
module doll_gesture_sequencer #(
    parameter int TICK_DIV  = 50000000,
    parameter int IDLE_WAVE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [2:0] req_gesture,
    output logic       req_ready,
    input  logic       idle_en,
    output logic [2:0] pose,
    output logic       busy,
    output logic       done
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic          ANIM_ON   = (IDLE_WAVE != 0);
    localparam logic [2:0]    G_WAVE    = 3'd1;

    typedef enum logic [1:0] {
        IDLE,
        IDLE_ANIM,
        RUN
    } state_t;

    // Gesture ROM: pose shown at each step of each gesture.
    function automatic logic [2:0] rom_pose(input logic [2:0] g, input logic [1:0] s);
        logic [2:0] p;
        case (g)
            3'd1:    p = s[0] ? 3'd5 : 3'd4;
            3'd2:    p = 3'd1;
            3'd3:    p = s[0] ? 3'd4 : 3'd5;
            3'd4:    p = (s == 2'd2) ? 3'd3 : ((s == 2'd0) ? 3'd1 : 3'd2);
            3'd5:    p = s[0] ? 3'd2 : 3'd3;
            3'd6:    p = 3'd2;
            3'd7:    p = 3'd3;
            default: p = 3'd0;
        endcase
        return p;
    endfunction

    function automatic logic [1:0] rom_last_step(input logic [2:0] g);
        logic [1:0] n;
        case (g)
            3'd1, 3'd4, 3'd5: n = 2'd3;
            3'd3:             n = 2'd2;
            default:          n = 2'd0;
        endcase
        return n;
    endfunction

    // Dwell is stored as (ticks - 1); only the single-step gestures hold for two ticks.
    function automatic logic [1:0] rom_dwell_last(input logic [2:0] g);
        logic [1:0] d;
        case (g)
            3'd2, 3'd6, 3'd7: d = 2'd1;
            default:          d = 2'd0;
        endcase
        return d;
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    gesture_q, gesture_d;
    logic [1:0]    step_q, step_d;
    logic [1:0]    dwell_q, dwell_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    pose_q, pose_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;

    logic tick;
    logic accept;
    logic anim_req;

    assign tick     = (presc_q == TICK_LAST);
    assign accept   = req_valid & ready_q;
    assign anim_req = ANIM_ON & idle_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gesture_q <= 3'd0;
            step_q    <= 2'd0;
            dwell_q   <= 2'd0;
            presc_q   <= '0;
            pose_q    <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            gesture_q <= gesture_d;
            step_q    <= step_d;
            dwell_q   <= dwell_d;
            presc_q   <= presc_d;
            pose_q    <= pose_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gesture_d = gesture_q;
        step_d    = step_q;
        dwell_d   = dwell_q;
        presc_d   = tick ? '0 : presc_q + PW'(1);
        pose_d    = pose_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        done_d    = 1'b0;

        // A request is only acceptable outside RUN, so it preempts both idle states.
        if (accept) begin
            state_d   = RUN;
            gesture_d = req_gesture;
            step_d    = 2'd0;
            dwell_d   = 2'd0;
            presc_d   = '0;
            pose_d    = rom_pose(req_gesture, 2'd0);
            busy_d    = 1'b1;
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    pose_d  = 3'd0;
                    if (anim_req) begin
                        state_d = IDLE_ANIM;
                        step_d  = 2'd0;
                        pose_d  = rom_pose(G_WAVE, 2'd0);
                    end
                end
                IDLE_ANIM: begin
                    if (!anim_req) begin
                        state_d = IDLE;
                        presc_d = '0;
                        pose_d  = 3'd0;
                    end else if (tick) begin
                        step_d = step_q + 2'd1;
                        pose_d = rom_pose(G_WAVE, step_q + 2'd1);
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (dwell_q != rom_dwell_last(gesture_q)) begin
                            dwell_d = dwell_q + 2'd1;
                        end else if (step_q != rom_last_step(gesture_q)) begin
                            step_d  = step_q + 2'd1;
                            dwell_d = 2'd0;
                            pose_d  = rom_pose(gesture_q, step_q + 2'd1);
                        end else begin
                            // The done cycle doubles as the one-cycle rest before any wave restart.
                            state_d = IDLE;
                            step_d  = 2'd0;
                            dwell_d = 2'd0;
                            presc_d = '0;
                            pose_d  = 3'd0;
                            busy_d  = 1'b0;
                            ready_d = 1'b1;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign pose      = pose_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign req_ready = ready_q;

endmodule

// File: tb/tb_doll_gesture_sequencer.sv
// Bench for doll_gesture_sequencer: a queue-based pose model checked every cycle, plus
// directed literal expectations for the gesture, handshake, idle wave and reset scenarios.
module tb_doll_gesture_sequencer;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_gesture = 3'd0;
    logic       idle_en = 1'b0;
    logic       req_ready;
    logic [2:0] pose;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    doll_gesture_sequencer #(
        .TICK_DIV (TICK_DIV),
        .IDLE_WAVE(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_gesture(req_gesture),
        .req_ready  (req_ready),
        .idle_en    (idle_en),
        .pose       (pose),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Gesture table as plain lists: poses, step count and dwell ticks per gesture.
    int tbl_pose [8][4] = '{'{0, 0, 0, 0}, '{4, 5, 4, 5}, '{1, 0, 0, 0}, '{5, 4, 5, 0},
                            '{1, 2, 3, 2}, '{3, 2, 3, 2}, '{2, 0, 0, 0}, '{3, 0, 0, 0}};
    int tbl_len  [8]    = '{1, 4, 1, 3, 4, 4, 1, 1};
    int tbl_dwell[8]    = '{1, 1, 2, 1, 1, 1, 2, 2};

    // Model: a run is a queue of per-cycle poses; the wave is a cycle counter.
    int m_pose  = 0;
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;
    bit m_ready = 1'b1;
    int m_mode  = 0;
    int m_k     = 0;
    int m_q[$];
    int m_g;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pose = 0; m_busy = 0; m_done = 0; m_ready = 1; m_mode = 0; m_k = 0;
            m_q.delete();
        end else begin
            m_done = 0;
            if (req_valid && m_ready) begin
                m_g = int'(req_gesture);
                m_q.delete();
                for (int s = 0; s < tbl_len[m_g]; s++)
                    for (int r = 0; r < tbl_dwell[m_g] * TICK_DIV; r++)
                        m_q.push_back(tbl_pose[m_g][s]);
                m_pose = m_q.pop_front();
                m_busy = 1; m_ready = 0; m_mode = 2;
            end else if (m_mode == 2) begin
                if (m_q.size() == 0) begin
                    m_pose = 0; m_busy = 0; m_done = 1; m_ready = 1; m_mode = 0;
                end else begin
                    m_pose = m_q.pop_front();
                end
            end else if (m_mode == 1) begin
                if (!idle_en) begin
                    m_mode = 0; m_pose = 0;
                end else begin
                    m_k++;
                    m_pose = (((m_k / TICK_DIV) % 2) == 0) ? 4 : 5;
                end
            end else if (idle_en) begin
                m_mode = 1; m_k = 0; m_pose = 4;
            end else begin
                m_pose = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model_pose", int'(pose), m_pose);
        checkOutput("model_busy", int'(busy), int'(m_busy));
        checkOutput("model_done", int'(done), int'(m_done));
        checkOutput("model_ready", int'(req_ready), int'(m_ready));
    end

    task automatic applyStimulus(input bit v, input int g, input bit ie);
        req_valid   = v;
        req_gesture = g[2:0];
        idle_en     = ie;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sc[16] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 2, 2, 2, 2};
        int wv[10] = '{4, 4, 4, 4, 5, 5, 5, 5, 4, 4};
        int pp[12] = '{5, 5, 5, 5, 4, 4, 4, 4, 5, 5, 5, 5};

        #1 rst_n = 1'b0;
        applyStimulus(0, 0, 0);
        repeat (3) waitCycle();
        checkOutput("rst_pose", int'(pose), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_ready", int'(req_ready), 1);
        rst_n = 1'b1;
        waitCycle();
        checkOutput("idle_pose", int'(pose), 0);

        $display("[TB] scissors");
        applyStimulus(1, 4, 0);
        waitCycle();
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("sc_pose", int'(pose), sc[i]);
            checkOutput("sc_busy", int'(busy), 1);
            checkOutput("sc_ready", int'(req_ready), 0);
            waitCycle();
        end
        checkOutput("sc_done", int'(done), 1);
        checkOutput("sc_done_pose", int'(pose), 0);
        checkOutput("sc_done_busy", int'(busy), 0);
        checkOutput("sc_done_ready", int'(req_ready), 1);
        waitCycle();
        checkOutput("sc_done_pulse", int'(done), 0);

        $display("[TB] rock then held draw");
        applyStimulus(1, 2, 0);
        waitCycle();
        applyStimulus(1, 7, 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("rock_pose", int'(pose), 1);
            checkOutput("rock_ready", int'(req_ready), 0);
            waitCycle();
        end
        checkOutput("rock_done", int'(done), 1);
        checkOutput("rock_rest", int'(pose), 0);
        waitCycle();
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("draw_pose", int'(pose), 3);
            checkOutput("draw_busy", int'(busy), 1);
            waitCycle();
        end
        checkOutput("draw_done", int'(done), 1);
        waitCycle();

        $display("[TB] idle wave then lose");
        applyStimulus(0, 0, 1);
        waitCycle();
        for (int i = 0; i < 10; i++) begin
            checkOutput("wave_pose", int'(pose), wv[i]);
            checkOutput("wave_busy", int'(busy), 0);
            checkOutput("wave_done", int'(done), 0);
            waitCycle();
        end
        applyStimulus(1, 6, 1);
        waitCycle();
        applyStimulus(0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("lose_pose", int'(pose), 2);
            checkOutput("lose_busy", int'(busy), 1);
            waitCycle();
        end
        checkOutput("lose_done", int'(done), 1);
        waitCycle();
        checkOutput("lose_wave_restart", int'(pose), 4);
        applyStimulus(0, 0, 0);
        repeat (2) waitCycle();

        $display("[TB] paper with simultaneous idle_en");
        applyStimulus(1, 3, 1);
        waitCycle();
        applyStimulus(0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            checkOutput("paper_pose", int'(pose), pp[i]);
            waitCycle();
        end
        checkOutput("paper_done", int'(done), 1);
        waitCycle();
        checkOutput("paper_wave_pose", int'(pose), 4);
        checkOutput("paper_wave_busy", int'(busy), 0);
        applyStimulus(0, 0, 0);
        repeat (2) waitCycle();

        $display("[TB] rest gesture with idle_en toggling");
        applyStimulus(1, 0, 0);
        waitCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, (i % 2) == 0);
            checkOutput("rest_pose", int'(pose), 0);
            checkOutput("rest_busy", int'(busy), 1);
            waitCycle();
        end
        checkOutput("rest_done", int'(done), 1);
        waitCycle();

        $display("[TB] reset mid-gesture");
        applyStimulus(1, 5, 0);
        waitCycle();
        applyStimulus(0, 0, 0);
        repeat (5) waitCycle();
        checkOutput("win_pose", int'(pose), 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_pose", int'(pose), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_done", int'(done), 0);
        checkOutput("async_rst_ready", int'(req_ready), 1);
        waitCycle();
        waitCycle();
        rst_n = 1'b1;
        waitCycle();
        checkOutput("post_rst_pose", int'(pose), 0);
        checkOutput("post_rst_busy", int'(busy), 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                          idle_en ^ ($urandom_range(0, 29) == 0));
            rst_n = ($urandom_range(0, 399) != 0);
            waitCycle();
        end
        rst_n = 1'b1;
        applyStimulus(0, 0, 0);
        repeat (2) waitCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/doll_gesture_sequencer.md
# doll_gesture_sequencer

Sequences the animated doll's two arm servos through timed multi-step gestures. The game FSM requests one gesture per round outcome through a valid/ready handshake. The block owns the 3-bit pose code that drives the servo pose mapper and PWM generators, and plays a preemptible idle wave animation when nothing is requested. Every pose step is timed by an internal tick prescaler.

## Interface

Parameters:
- TICK_DIV, 50000000 — clock cycles per dwell tick (0.5 s at 100 MHz); the bench uses 4
- IDLE_WAVE, 1 — 1 enables the idle animation logic; 0 removes it (idle_en ignored)

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  gesture request valid
- req_gesture  in  3  gesture ID, sampled on accept
- req_ready  out  1  block can accept a request this cycle
- idle_en  in  1  play idle wave animation while no gesture runs
- pose  out  3  pose code to servo mapper: 0 rest, 1 both 45°, 2 both 90°, 3 both 135°, 4 L45/R135, 5 L135/R45
- busy  out  1  a requested gesture is playing
- done  out  1  one-cycle pulse on gesture completion

## Operation

- All outputs are registered.
- Reset values: pose=0, busy=0, done=0, req_ready=1. The prescaler, step index and FSM clear to IDLE.
- Gesture table, listed as steps (pose:dwell ticks):
  - 0 REST: 0:1
  - 1 WAVE: 4:1, 5:1, 4:1, 5:1
  - 2 ROCK: 1:2
  - 3 PAPER: 5:1, 4:1, 5:1
  - 4 SCISSORS: 1:1, 2:1, 3:1, 2:1
  - 5 WIN: 3:1, 2:1, 3:1, 2:1
  - 6 LOSE: 2:2
  - 7 DRAW: 3:2
- The table is a constant ROM, at most 4 steps per gesture. Step count and per-step dwell (1–2 ticks) come from the table.
- FSM states: IDLE, IDLE_ANIM, RUN.
  - IDLE: pose=0, req_ready=1. If idle_en=1 and IDLE_WAVE=1, go to IDLE_ANIM next cycle.
  - IDLE_ANIM: plays the WAVE steps cyclically; after step 3 it wraps to step 0. busy=0, req_ready=1.
    - idle_en=0 → IDLE next cycle, pose=0 next cycle.
  - RUN: entered on accept from IDLE or IDLE_ANIM (idle animation is cut immediately). req_ready=0, busy=1.
    - Steps advance when the dwell count expires.
    - After the final step expires: pose=0, busy=0, done=1, req_ready=1, all in the same cycle. Go to IDLE, or to IDLE_ANIM if idle_en=1.
- Accept: req_valid & req_ready at a rising edge. req_gesture is latched. Requests during RUN are not accepted; the requester must hold req_valid.
- Prescaler: counts 0..TICK_DIV-1 and restarts at 0 on every accept and on every IDLE→IDLE_ANIM entry. A tick is the cycle the count equals TICK_DIV-1.
- Arithmetic: prescaler width clog2(TICK_DIV), wrap at TICK_DIV-1. Dwell counter 2 bits. Step index 2 bits.

## Timing

- Accept at edge N → pose = step0 pose, busy=1, req_ready=0 after edge N.
- Each step holds pose for exactly dwell×TICK_DIV cycles.
- Gesture total = Σdwell×TICK_DIV cycles from edge N to the edge that raises done.
- Back-to-back: a request valid in the done cycle is accepted at the next edge. The intervening rest pose lasts exactly 1 cycle.
- req_valid and idle_en rising in the same cycle: the request wins; IDLE_ANIM is not entered.
- idle_en dropping during RUN has no effect until completion.
- Reset asserted mid-gesture: all outputs take their reset values immediately (asynchronous); no done pulse.
- done is never asserted for the idle animation.

## Test plan

- Reset: assert rst_n=0 mid-RUN → pose=0, busy=0, done=0, req_ready=1 asynchronously. After release, IDLE with pose=0.
- TICK_DIV=4, request gesture 4 (SCISSORS) →
  - pose 1, 2, 3, 2, each for 4 cycles
  - done pulses 16 cycles after accept
  - pose=0, busy=0 the same cycle
- Request gesture 2 (ROCK) → pose=1 for 8 cycles, then done. Hold req_valid with gesture 7 through the run → accepted in the done cycle; pose=3 starts 1 cycle later and lasts 8 cycles.
- idle_en=1 with no request → pose 4, 5, 4, 5, 4… every 4 cycles, busy=0, no done. Request gesture 6 mid-step → pose=2 at the next cycle, busy=1.
- Same-cycle req_valid (gesture 3) and idle_en rise → PAPER runs (5, 4, 5). After done, with idle_en still 1, the wave starts at pose 4.
- Gesture 0 → pose=0 for 4 cycles, busy=1, then done. Toggle idle_en during RUN → no effect on the sequence.
